// File: rtl/div_stall_unit.sv
// Multi-cycle restoring divider for the EX stage.
// Raises a stall request to CTRL while a divide is in flight.
module div_stall_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_FREE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dsor_q, dsor_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               go;
    logic               a_neg, b_neg;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_nx, quo_nx;

    assign go    = start_i & ~annul_i;
    assign a_neg = signed_i & opdata1_i[WIDTH-1];
    assign b_neg = signed_i & opdata2_i[WIDTH-1];

    // Trial subtract on the shifted partial remainder; non-negative sets the bit.
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsor_q};

    always_comb begin
        if (!trial[WIDTH]) begin
            rem_nx = trial[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_nx = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dsor_d   = dsor_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;
        ready_d  = ready_q;
        unique case (state_q)
            S_FREE: begin
                if (go) begin
                    if (opdata2_i == '0) begin
                        state_d = S_DIVZERO;
                    end else begin
                        state_d = S_ON;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = a_neg ? -opdata1_i : opdata1_i;
                        dsor_d  = b_neg ? -opdata2_i : opdata2_i;
                        neg_q_d = a_neg ^ b_neg;
                        neg_r_d = a_neg;
                    end
                end
            end
            S_DIVZERO: begin
                if (annul_i) begin
                    state_d = S_FREE;
                end else begin
                    state_d  = S_END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            S_ON: begin
                if (annul_i) begin
                    state_d = S_FREE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = S_END;
                        ready_d  = 1'b1;
                        result_d = {neg_r_q ? -rem_nx : rem_nx,
                                    neg_q_q ? -quo_nx : quo_nx};
                    end
                end
            end
            S_END: begin
                if (!start_i || annul_i) begin
                    state_d = S_FREE;
                    ready_d = 1'b0;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsor_q   <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsor_q   <= dsor_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~annul_i & ~ready_q;
endmodule

// File: tb/tb_div_stall_unit.sv
// Directed bench for div_stall_unit with a transaction-level reference model
// checked every cycle, plus literal expectations per divide.
module tb_div_stall_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks = 0;
    int errors = 0;

    div_stall_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    // Reference model: idle / busy with a cycle countdown / ready.
    logic        m_busy = 1'b0;
    logic        m_ready = 1'b0;
    int          m_left = 0;
    logic [63:0] m_pend = '0;
    logic [63:0] m_result = '0;

    function automatic logic [63:0] ref_div(input logic sg,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) return 64'd0;
        if (!sg) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end
        return {r, q};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   = 1'b0;
            m_ready  = 1'b0;
            m_left   = 0;
            m_result = '0;
        end else if (m_ready) begin
            if (!start_i || annul_i) m_ready = 1'b0;
        end else if (m_busy) begin
            if (annul_i) begin
                m_busy = 1'b0;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy   = 1'b0;
                    m_ready  = 1'b1;
                    m_result = m_pend;
                end
            end
        end else if (start_i && !annul_i) begin
            m_busy = 1'b1;
            m_left = (opdata2_i == 0) ? 1 : 32;
            m_pend = ref_div(signed_i, opdata1_i, opdata2_i);
        end
    end

    always @(negedge clk) begin
        checks++;
        if (ready_o !== m_ready) begin
            errors++;
            $display("FAIL model_ready t=%0t got %b exp %b", $time, ready_o, m_ready);
        end
        checks++;
        if (stallreq_o !== (start_i & ~annul_i & ~m_ready)) begin
            errors++;
            $display("FAIL model_stall t=%0t got %b exp %b", $time, stallreq_o,
                     start_i & ~annul_i & ~m_ready);
        end
        checks++;
        if (result_o !== m_result) begin
            errors++;
            $display("FAIL model_result t=%0t got %h exp %h", $time, result_o, m_result);
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic do_div(input string name, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        int stalls;
        logic done;
        @(posedge clk);
        #1;
        start_i   = 1'b1;
        signed_i  = sg;
        opdata1_i = a;
        opdata2_i = b;
        n = 0;
        stalls = 0;
        done = 1'b0;
        while (!done && n < 100) begin
            @(negedge clk);
            if (n == 3) begin
                opdata1_i = 32'hDEAD_BEEF;
                opdata2_i = 32'h0000_0005;
                signed_i  = ~sg;
            end
            if (ready_o) begin
                done = 1'b1;
                chk({name, "_result"}, result_o, exp);
                chk({name, "_latency"}, 64'(n), 64'(lat));
                chk({name, "_stall_at_ready"}, 64'(stallreq_o), 64'd0);
            end else begin
                if (stallreq_o) stalls++;
                n++;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout got no ready exp ready", name);
        end
        chk({name, "_stall_cycles"}, 64'(stalls), 64'(lat));
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        chk("reset_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33);
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 64'd0, 2);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33);
        do_div("div_m8_m3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 64'hFFFFFFFE_00000002, 33);
        do_div("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000, 33);
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, 33);

        // Annul mid-divide.
        @(posedge clk);
        #1;
        start_i = 1'b1;
        signed_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        repeat (10) @(posedge clk);
        #1 annul_i = 1'b1;
        @(negedge clk);
        chk("annul_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        repeat (40) begin
            @(negedge clk);
            chk("annul_no_ready", 64'(ready_o), 64'd0);
        end
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

        // Asynchronous reset mid-divide.
        @(posedge clk);
        #1;
        start_i = 1'b1;
        opdata1_i = 32'd77;
        opdata2_i = 32'd4;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_ready", 64'(ready_o), 64'd0);
        chk("arst_result", result_o, 64'd0);
        start_i = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        do_div("div_after_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 33);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/div_stall_unit.md
# div_stall_unit

Multi-cycle 32-bit integer divider for the EX stage, and the requesting side of the pipeline stall interface. While a divide is in flight it raises `stallreq_o`, which CTRL turns into the EX-and-earlier stall pattern on `stall`. It returns a 64-bit {remainder, quotient} to EX and supports signed and unsigned operation, divide-by-zero, and annulment when the instruction is flushed.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the result is 2*`WIDTH`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  EX holds this high for a DIV/DIVU instruction until `ready_o` is seen.
- `signed_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with the operands.
- `opdata1_i`  in  WIDTH  dividend.
- `opdata2_i`  in  WIDTH  divisor.
- `annul_i`  in  1  abort the current divide (flush); has priority over `start_i`.
- `result_o`  out  2*WIDTH  bits [63:32] are the remainder, bits [31:0] the quotient; valid while `ready_o`=1.
- `ready_o`  out  1  result valid (registered).
- `stallreq_o`  out  1  stall request to CTRL; equals `start_i & ~annul_i & ~ready_o` (combinational).

## Operation
State machine has four states: FREE, DIVZERO, ON, END. Reset state is FREE.
- **FREE:**
  - If `start_i & ~annul_i` and the divisor is nonzero: capture operands and sign info, then go to ON with `cnt`=0.
  - If `start_i & ~annul_i` and the divisor is zero: go to DIVZERO.
  - Otherwise stay in FREE.
- **DIVZERO:** go to END with `result_o`=0.
- **ON:** one restoring-division step per cycle on the absolute values. Each step is a 33-bit trial subtract of the divisor from the shifted partial remainder; the quotient bit is 1 when the result is non-negative. `cnt` increments each step.
  - If `annul_i`=1: go to FREE immediately, discard work, leave `result_o` unchanged.
  - After the step with `cnt`=31: apply sign fix-up, register the result, go to END.
- **END:** `ready_o`=1 and `result_o` is held.
  - Stay in END while `start_i`=1.
  - Go to FREE when `start_i`=0 or `annul_i`=1, with `ready_o`=0 in the next cycle.
- **Signed fix-up:**
  - Operands are converted to magnitudes before the steps.
  - The quotient is negated when the dividend and divisor signs differ.
  - The remainder takes the sign of the dividend.
  - -2^31 / -1 wraps: quotient 0x80000000, remainder 0.
- Operands are captured once when leaving FREE. Later changes on `opdata*_i` or `signed_i` are ignored.
- `start_i` falling while in ON without `annul_i` does not abort the divide. It finishes into END, then drops to FREE on the next cycle.

## Timing
- Reset values: state FREE, `cnt` 0, `result_o` 0, `ready_o` 0. `stallreq_o` follows its equation, so it is 0 when `start_i` is 0.
- Asserting `rst` mid-operation returns the block to FREE immediately, with all outputs at their reset values.
- Latency for a normal divide: `start_i` first sampled at edge T gives 32 ON cycles and `ready_o`=1 in cycle T+33.
- Latency for divide-by-zero: `ready_o`=1 in cycle T+2.
- `stallreq_o` is high from the first cycle `start_i` is high until the cycle `ready_o` rises. The ready cycle is therefore unstalled and EX consumes `result_o` then.
- `annul_i` in any state forces `stallreq_o`=0 in the same cycle, and the state is FREE by the next cycle.
- Back-to-back divides: EX must drop `start_i` for at least one cycle between instructions. The END→FREE transition requires `start_i`=0.

## Test plan
- **Unsigned divide:** DIVU 100/7 with `start_i` held → `stallreq_o`=1 for 33 cycles, then `ready_o`=1 at T+33 with `result_o`=0x00000002_0000000E. `stallreq_o`=0 in that cycle.
- **Signed divide:** DIV -7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- **Signed overflow:** DIV 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
- **Divide by zero:** DIVU 5/0 → `ready_o`=1 at T+2, `result_o`=0, `stallreq_o` high only for cycles T and T+1.
- **Annul:** `annul_i` pulsed at T+10 → `stallreq_o`=0 that cycle, state FREE at T+11, `ready_o` never asserts. A following DIVU 9/3 then completes correctly at its own start+33 (quotient 3, remainder 0).
- **Reset mid-divide:** `rst` asserted at T+5, asynchronously between edges → outputs immediately at reset values; a divide started after reset release produces a correct result.
